load_store_unit: RTL and testbench

- Initiator side of the data-memory interface: takes load/store requests from the CPU execute stage and drives the word-addressed data memory (mem_read, mem_write, data_addr, write_data, read_data).
- Supports the RV32I load/store set (LB/LH/LW/LBU/LHU, SB/SH/SW).
- Memory is word-only, so sub-word stores use an internal read-modify-write sequence.
- Returns sign- or zero-extended load data and flags misaligned, out-of-range or illegal accesses.

---
 rtl/load_store_unit.sv | 161 ++++++++++++++++
 tb/tb_load_store_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// RV32I load/store initiator for a word-only data memory.
// Sub-word stores are done as read-modify-write; loads are extended by width and signedness.
module load_store_unit #(
  parameter int MEM_WORDS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] data_addr,
  output logic [31:0] write_data,
  input  logic [31:0] read_data
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOAD      = 3'd1;
  localparam logic [2:0] S_STORE     = 3'd2;
  localparam logic [2:0] S_RMW_READ  = 3'd3;
  localparam logic [2:0] S_RMW_WRITE = 3'd4;
  localparam logic [2:0] S_RESP      = 3'd5;

  localparam logic [31:0] ADDR_LIMIT = 32'(4 * MEM_WORDS);

  logic [2:0]  state_reg, state_next;
  logic [31:0] addr_reg;
  logic [2:0]  funct3_reg;
  logic [31:0] wdata_reg;
  logic [31:0] word_reg;
  logic [31:0] rdata_reg;
  logic        error_reg;

  logic        accept;
  logic        misaligned;
  logic        bad_funct3;
  logic        req_err;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_ext;
  logic [3:0]  byte_en;
  logic [31:0] wdata_lane;
  logic [31:0] merged_word;

  assign accept = req_valid && (state_reg == S_IDLE);

  always_comb begin
    misaligned = 1'b0;
    case (req_funct3[1:0])
      2'd1:    misaligned = req_addr[0];
      2'd2:    misaligned = (req_addr[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
  end

  assign bad_funct3 = req_write ? (req_funct3 > 3'd2)
                                : ((req_funct3 == 3'd3) || (req_funct3[2:1] == 2'b11));
  assign req_err = misaligned || bad_funct3 || (req_addr >= ADDR_LIMIT);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          if (req_err)
            state_next = S_RESP;
          else if (!req_write)
            state_next = S_LOAD;
          else if (req_funct3 == 3'd2)
            state_next = S_STORE;
          else
            state_next = S_RMW_READ;
        end
      end
      S_LOAD:      state_next = S_RESP;
      S_STORE:     state_next = S_RESP;
      S_RMW_READ:  state_next = S_RMW_WRITE;
      S_RMW_WRITE: state_next = S_RESP;
      default:     state_next = S_IDLE;
    endcase
  end

  // Load lane selection and extension from the live memory word.
  always_comb begin
    case (addr_reg[1:0])
      2'd0:    lane_byte = read_data[7:0];
      2'd1:    lane_byte = read_data[15:8];
      2'd2:    lane_byte = read_data[23:16];
      default: lane_byte = read_data[31:24];
    endcase
    lane_half = addr_reg[1] ? read_data[31:16] : read_data[15:0];
    case (funct3_reg)
      3'd0:    load_ext = {{24{lane_byte[7]}}, lane_byte};
      3'd1:    load_ext = {{16{lane_half[15]}}, lane_half};
      3'd4:    load_ext = {24'd0, lane_byte};
      3'd5:    load_ext = {16'd0, lane_half};
      default: load_ext = read_data;
    endcase
  end

  // Byte enables for the merge: SB touches one lane, SH touches a lane pair.
  always_comb begin
    if (funct3_reg[1:0] == 2'd0) begin
      byte_en    = 4'b0001 << addr_reg[1:0];
      wdata_lane = {4{wdata_reg[7:0]}};
    end else begin
      byte_en    = addr_reg[1] ? 4'b1100 : 4'b0011;
      wdata_lane = {2{wdata_reg[15:0]}};
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_merge
      assign merged_word[8*gi +: 8] = byte_en[gi] ? wdata_lane[8*gi +: 8] : word_reg[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= S_IDLE;
      addr_reg   <= 32'd0;
      funct3_reg <= 3'd0;
      wdata_reg  <= 32'd0;
      word_reg   <= 32'd0;
      rdata_reg  <= 32'd0;
      error_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        addr_reg   <= req_addr;
        funct3_reg <= req_funct3;
        wdata_reg  <= req_wdata;
        rdata_reg  <= 32'd0;
        error_reg  <= req_err;
      end
      if (state_reg == S_LOAD)
        rdata_reg <= load_ext;
      if (state_reg == S_RMW_READ)
        word_reg <= read_data;
    end
  end

  // Enables decode straight from state so an async reset drops them at once.
  assign req_ready  = (state_reg == S_IDLE);
  assign mem_read   = (state_reg == S_LOAD) || (state_reg == S_RMW_READ);
  assign mem_write  = (state_reg == S_STORE) || (state_reg == S_RMW_WRITE);
  assign data_addr  = (mem_read || mem_write) ? {addr_reg[31:2], 2'b00} : 32'd0;
  assign write_data = (state_reg == S_STORE)     ? wdata_reg   :
                      (state_reg == S_RMW_WRITE) ? merged_word : 32'd0;
  assign resp_valid = (state_reg == S_RESP);
  assign resp_rdata = resp_valid ? rdata_reg : 32'd0;
  assign resp_error = resp_valid && error_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: word memory model, latency, data, error and reset checks.
module tb_load_store_unit;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] data_addr;
  logic [31:0] write_data;
  logic [31:0] read_data;

  logic [31:0] mem [0:31];
  logic        mem_init;
  int          checks;
  int          failures;

  load_store_unit #(.MEM_WORDS(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_error (resp_error),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .data_addr  (data_addr),
    .write_data (write_data),
    .read_data  (read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word memory: combinational read, write at the rising edge.
  assign read_data = mem[data_addr[6:2]];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'd0;
      mem[2]  <= 32'h1122_3344;
      mem[4]  <= 32'h8899_AABB;
      mem[31] <= 32'hCAFE_F00D;
    end else if (mem_write) begin
      mem[data_addr[6:2]] <= write_data;
    end
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic do_req(input string name, input logic w, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int exp_lat, input logic [31:0] exp_rd, input logic exp_err,
                        input int exp_rds, input int exp_wrs,
                        input logic [31:0] exp_addr, input logic [31:0] exp_wdata);
    int lat, rds, wrs, viol;
    logic [31:0] seen_addr, seen_wd, got_rd;
    logic got_err;
    lat = 0; rds = 0; wrs = 0; viol = 0;
    seen_addr = 32'd0; seen_wd = 32'd0; got_rd = 32'd0; got_err = 1'b0;
    @(negedge clk);
    check_value({name, " ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1;
    // Scramble the request bus to confirm the unit latched it.
    req_valid = 1'b0; req_write = ~w; req_funct3 = 3'd7; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5A5A_5A5A;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (mem_read) rds++;
      if (mem_write) begin wrs++; seen_wd = write_data; end
      if (mem_read || mem_write) seen_addr = data_addr;
      if (mem_read && mem_write) viol++;
      if (!(mem_read || mem_write) && data_addr != 32'd0) viol++;
      if (!mem_write && write_data != 32'd0) viol++;
      if (resp_valid) begin
        lat = k; got_rd = resp_rdata; got_err = resp_error;
        break;
      end
    end
    check_value({name, " latency"}, 32'(lat), 32'(exp_lat));
    check_value({name, " rdata"}, got_rd, exp_rd);
    check_value({name, " error"}, 32'(got_err), 32'(exp_err));
    check_value({name, " reads"}, 32'(rds), 32'(exp_rds));
    check_value({name, " writes"}, 32'(wrs), 32'(exp_wrs));
    check_value({name, " addr"}, seen_addr, exp_addr);
    check_value({name, " wdata"}, seen_wd, exp_wdata);
    check_value({name, " enables"}, 32'(viol), 32'd0);
    @(negedge clk);
    check_value({name, " resp_drop"}, 32'(resp_valid), 32'd0);
    $display("txn %s lat=%0d rdata=%h err=%0d reads=%0d writes=%0d", name, lat, got_rd, got_err, rds, wrs);
  endtask

  logic        b2b_ready [1:6];
  logic        b2b_rv    [1:6];
  logic [31:0] b2b_rd    [1:6];

  initial begin
    checks = 0; failures = 0;
    reset = 1'b0; mem_init = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
    #1;
    check_value("reset req_ready", 32'(req_ready), 32'd1);
    check_value("reset resp_valid", 32'(resp_valid), 32'd0);
    check_value("reset mem_en", {30'd0, mem_read, mem_write}, 32'd0);
    check_value("reset data_addr", data_addr, 32'd0);
    check_value("reset write_data", write_data, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    mem_init = 1'b0; reset = 1'b1;

    do_req("LW 0x10",  1'b0, 3'd2, 32'h10, 32'd0, 2, 32'h8899_AABB, 1'b0, 1, 0, 32'h10, 32'd0);
    do_req("LB 0x13",  1'b0, 3'd0, 32'h13, 32'd0, 2, 32'hFFFF_FF88, 1'b0, 1, 0, 32'h10, 32'd0);
    do_req("LBU 0x13", 1'b0, 3'd4, 32'h13, 32'd0, 2, 32'h0000_0088, 1'b0, 1, 0, 32'h10, 32'd0);
    do_req("LH 0x12",  1'b0, 3'd1, 32'h12, 32'd0, 2, 32'hFFFF_8899, 1'b0, 1, 0, 32'h10, 32'd0);
    do_req("LHU 0x10", 1'b0, 3'd5, 32'h10, 32'd0, 2, 32'h0000_AABB, 1'b0, 1, 0, 32'h10, 32'd0);
    do_req("LB 0x10",  1'b0, 3'd0, 32'h10, 32'd0, 2, 32'hFFFF_FFBB, 1'b0, 1, 0, 32'h10, 32'd0);
    do_req("LW 0x7C",  1'b0, 3'd2, 32'h7C, 32'd0, 2, 32'hCAFE_F00D, 1'b0, 1, 0, 32'h7C, 32'd0);
    do_req("SB 0x11",  1'b1, 3'd0, 32'h11, 32'h1234_56CC, 3, 32'd0, 1'b0, 1, 1, 32'h10, 32'h8899_CCBB);
    do_req("LW after SB", 1'b0, 3'd2, 32'h10, 32'd0, 2, 32'h8899_CCBB, 1'b0, 1, 0, 32'h10, 32'd0);
    do_req("SH 0x12",  1'b1, 3'd1, 32'h12, 32'h0000_7777, 3, 32'd0, 1'b0, 1, 1, 32'h10, 32'h7777_CCBB);
    do_req("LW after SH", 1'b0, 3'd2, 32'h10, 32'd0, 2, 32'h7777_CCBB, 1'b0, 1, 0, 32'h10, 32'd0);
    do_req("err LW 0x12", 1'b0, 3'd2, 32'h12, 32'd0, 1, 32'd0, 1'b1, 0, 0, 32'd0, 32'd0);
    do_req("err SH 0x11", 1'b1, 3'd1, 32'h11, 32'h0000_FFFF, 1, 32'd0, 1'b1, 0, 0, 32'd0, 32'd0);
    do_req("err LB 0x80", 1'b0, 3'd0, 32'h80, 32'd0, 1, 32'd0, 1'b1, 0, 0, 32'd0, 32'd0);
    do_req("err load f3=3", 1'b0, 3'd3, 32'h10, 32'd0, 1, 32'd0, 1'b1, 0, 0, 32'd0, 32'd0);
    do_req("err store f3=3", 1'b1, 3'd3, 32'h10, 32'hFFFF_FFFF, 1, 32'd0, 1'b1, 0, 0, 32'd0, 32'd0);
    do_req("LW 0x10 intact", 1'b0, 3'd2, 32'h10, 32'd0, 2, 32'h7777_CCBB, 1'b0, 1, 0, 32'h10, 32'd0);

    // Back-to-back: SW then LW with req_valid held high.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd2; req_addr = 32'h04; req_wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    req_write = 1'b0; req_funct3 = 3'd2; req_addr = 32'h04; req_wdata = 32'd0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      b2b_ready[k] = req_ready; b2b_rv[k] = resp_valid; b2b_rd[k] = resp_rdata;
      if (k == 3) begin
        @(posedge clk);
        #1;
        req_valid = 1'b0;
      end
    end
    check_value("b2b ready c1", 32'(b2b_ready[1]), 32'd0);
    check_value("b2b ready c2", 32'(b2b_ready[2]), 32'd0);
    check_value("b2b sw resp c2", 32'(b2b_rv[2]), 32'd1);
    check_value("b2b ready c3", 32'(b2b_ready[3]), 32'd1);
    check_value("b2b ready c4", 32'(b2b_ready[4]), 32'd0);
    check_value("b2b lw resp c5", 32'(b2b_rv[5]), 32'd1);
    check_value("b2b lw rdata c5", b2b_rd[5], 32'hDEAD_BEEF);
    check_value("b2b mem word 1", mem[1], 32'hDEAD_BEEF);
    $display("txn b2b SW/LW 0x04 ready=%b%b%b%b resp_c2=%b resp_c5=%b rdata=%h",
             b2b_ready[1], b2b_ready[2], b2b_ready[3], b2b_ready[4], b2b_rv[2], b2b_rv[5], b2b_rd[5]);

    // Reset asserted in the middle of the RMW write cycle of SB 0x08.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd0; req_addr = 32'h08; req_wdata = 32'h0000_00AA;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #2;
    check_value("rst pre mem_write", 32'(mem_write), 32'd1);
    reset = 1'b0;
    #1;
    check_value("rst mem_write", 32'(mem_write), 32'd0);
    check_value("rst mem_read", 32'(mem_read), 32'd0);
    check_value("rst data_addr", data_addr, 32'd0);
    check_value("rst write_data", write_data, 32'd0);
    check_value("rst resp", {30'd0, resp_valid, resp_error}, 32'd0);
    check_value("rst resp_rdata", resp_rdata, 32'd0);
    check_value("rst req_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_value("rst mem word 2", mem[2], 32'h1122_3344);
    check_value("rst ready after release", 32'(req_ready), 32'd1);
    $display("txn reset during SB 0x08 word=%h ready=%b", mem[2], req_ready);
    do_req("LB 0x08 after rst", 1'b0, 3'd0, 32'h08, 32'd0, 2, 32'h0000_0044, 1'b0, 1, 0, 32'h08, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=%0d expected=%0d", 0, 1);
    $fatal(1, "bench timeout");
  end

endmodule
